sync_fifo_fwft: RTL

//  Single-clock FIFO with integrated dual-port storage, parametrised width/depth.

---
 rtl/sync_fifo_fwft_pkg.sv | 13 +
 rtl/fifo_dpram.sv | 35 +++
 rtl/sync_fifo_fwft.sv | 95 +++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared defaults, read-mode encodings and depth helper for the single-clock FIFO.
package sync_fifo_fwft_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 3;
  localparam int FWFT_STD  = 0;  // registered read, one-cycle latency
  localparam int FWFT_FALL = 1;  // head word always presented on dout

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Dual-port storage: one write port, one read address with registered and combinational data.
// Latency: rdata_c same cycle, rdata_q one cycle after re.
// Backpressure: none; the owner gates we/re.
module fifo_dpram
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_q,
  output logic [DW-1:0] rdata_c
);

  logic [DW-1:0] mem [depth_of(AW)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is cleared; array contents are unreachable after reset anyway.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with occupancy, almost flags, sticky errors and selectable FWFT read.
// Latency: write visible next cycle; FWFT=0 dout one cycle after r_en, FWFT=1 dout combinational.
// Backpressure: writes dropped when full, reads ignored when empty, both recorded as sticky errors.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int AF_TH = 6,
  parameter int AE_TH = 1,
  parameter int FWFT  = FWFT_STD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_en,
  input  logic [DW-1:0] din,
  input  logic          r_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  if (AW < 1) begin : g_bad_aw
    $error("sync_fifo_fwft: AW must be >= 1");
  end
  if (AF_TH < 1 || AF_TH > depth_of(AW)) begin : g_bad_af
    $error("sync_fifo_fwft: AF_TH out of range 1..DEPTH");
  end
  if (AE_TH < 0 || AE_TH >= depth_of(AW)) begin : g_bad_ae
    $error("sync_fifo_fwft: AE_TH out of range 0..DEPTH-1");
  end
  if (FWFT != FWFT_STD && FWFT != FWFT_FALL) begin : g_bad_mode
    $error("sync_fifo_fwft: FWFT must be 0 or 1");
  end

  localparam logic [AW:0] AF_C    = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_TH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wptr, rptr;
  logic          wr_acc, rd_acc;
  logic          dv_q;
  logic [DW-1:0] rd_q, rd_c;

  // Flags derive from the registered pointers only, so they move on the accepting edge.
  assign count        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      if (wr_acc)       wptr      <= wptr + PTR_ONE;
      if (rd_acc)       rptr      <= rptr + PTR_ONE;
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
      dv_q <= rd_acc;
    end
  end

  fifo_dpram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_acc),
    .waddr   (wptr[AW-1:0]),
    .wdata   (din),
    .re      (rd_acc),
    .raddr   (rptr[AW-1:0]),
    .rdata_q (rd_q),
    .rdata_c (rd_c)
  );

  assign dout       = (FWFT == FWFT_FALL) ? rd_c   : rd_q;
  assign dout_valid = (FWFT == FWFT_FALL) ? ~empty : dv_q;

endmodule
